// File: rtl/alu_share_pkg.sv
// Shared types and constants for the two-requester ALU sharing controller.
// Holds the controller states, ALU op encodings and NZCV bit positions.
package alu_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic, purely combinational.
// On contention the requester that was not served last wins.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external ALU between two requesters with round-robin arbitration,
// registered operands, captured result/flags and the architectural NZCV register.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int PRIO_INIT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_srcA,
  input  logic [2*WIDTH-1:0] req_srcB,
  input  logic [3:0]         req_alu_control,
  input  logic [1:0]         req_set_flags,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic [3:0]         rsp_flags,
  output logic [WIDTH-1:0]   alu_srcA,
  output logic [WIDTH-1:0]   alu_srcB,
  output logic [1:0]         alu_control,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_zero,
  input  logic               alu_carry,
  input  logic               alu_overflow,
  output logic [3:0]         flags_nzcv
);

  localparam logic PRIO_BIT = (PRIO_INIT != 0);

  state_e     state;
  logic       last_grant;
  logic       op_tag;
  logic       op_set_flags;
  logic [1:0] grant;
  logic       sel;
  logic [3:0] nzcv_p1;

  function automatic logic [3:0] pack_nzcv(input logic n, input logic z,
                                           input logic c, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  rr_arbiter2 u_arb (
    .valid      (req_valid),
    .last_grant (last_grant),
    .enable     ((state == IDLE) && !reset),
    .grant      (grant)
  );

  assign req_ready = grant;
  assign sel       = grant[1];
  // N comes from the result MSB; the ALU's own flags cover Z, C and V only
  assign nzcv_p1   = pack_nzcv(alu_result[WIDTH-1], alu_zero, alu_carry, alu_overflow);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= ~PRIO_BIT;
      op_tag       <= 1'b0;
      op_set_flags <= 1'b0;
      alu_srcA     <= '0;
      alu_srcB     <= '0;
      alu_control  <= 2'b00;
      rsp_valid    <= 2'b00;
      rsp_result   <= '0;
      rsp_flags    <= 4'b0000;
      flags_nzcv   <= 4'b0000;
    end else begin
      case (state)
        // Stage p0: latch the granted request into the operand registers
        IDLE: begin
          if (|grant) begin
            alu_srcA     <= req_srcA[sel*WIDTH +: WIDTH];
            alu_srcB     <= req_srcB[sel*WIDTH +: WIDTH];
            alu_control  <= req_alu_control[sel*2 +: 2];
            op_set_flags <= req_set_flags[sel];
            op_tag       <= sel;
            state        <= EXEC;
          end
        end
        // Stage p1: capture ALU output and optionally commit flags
        EXEC: begin
          rsp_result <= alu_result;
          rsp_flags  <= nzcv_p1;
          if (op_set_flags) begin
            flags_nzcv <= nzcv_p1;
          end
          rsp_valid  <= onehot2(op_tag);
          state      <= RESP;
        end
        // Stage p2: hold the response until the tagged requester takes it
        RESP: begin
          if (rsp_ready[op_tag]) begin
            rsp_valid  <= 2'b00;
            last_grant <= op_tag;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Randomized self-checking bench for alu_share_ctrl with a behavioural ALU
// and a transaction-level reference for grants, results and NZCV flags.
module tb_alu_share_ctrl;
  import alu_share_pkg::*;

  localparam int W = 32;
  localparam int PRIO = 0;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     req_valid, req_ready, req_set_flags;
  logic [2*W-1:0] req_srcA, req_srcB;
  logic [3:0]     req_alu_control;
  logic [1:0]     rsp_valid, rsp_ready;
  logic [W-1:0]   rsp_result;
  logic [3:0]     rsp_flags;
  logic [W-1:0]   alu_srcA, alu_srcB, alu_result;
  logic [1:0]     alu_control;
  logic           alu_zero, alu_carry, alu_overflow;
  logic [3:0]     flags_nzcv;
  logic [W+3:0]   alu_out;

  int checks = 0;
  int failures = 0;

  logic         rr_next;
  logic [3:0]   exp_flags;
  logic [1:0]   t_op [2];
  logic [W-1:0] t_a  [2];
  logic [W-1:0] t_b  [2];
  logic         t_sf [2];
  int           g;
  int           order [4];

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(W), .PRIO_INIT(PRIO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_srcA(req_srcA), .req_srcB(req_srcB),
    .req_alu_control(req_alu_control), .req_set_flags(req_set_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .flags_nzcv(flags_nzcv)
  );

  // Returns {result, N, Z, C, V}; C on SUB means "no borrow"
  function automatic logic [W+3:0] ref_alu(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, v;
    s = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[W-1:0];
        c = s[W];
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      default: begin
        r = a - b;
        c = (a >= b);
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
    endcase
    return {r, r[W-1], (r == '0), c, v};
  endfunction

  assign alu_out      = ref_alu(alu_control, alu_srcA, alu_srcB);
  assign alu_result   = alu_out[W+3:4];
  assign alu_zero     = alu_out[2];
  assign alu_carry    = alu_out[1];
  assign alu_overflow = alu_out[0];

  function automatic logic [1:0] exp_grant(input logic [1:0] v);
    if (v == 2'b11) return rr_next ? 2'b10 : 2'b01;
    return v;
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic sf);
    t_op[i] = op; t_a[i] = a; t_b[i] = b; t_sf[i] = sf;
    req_srcA[i*W +: W]        = a;
    req_srcB[i*W +: W]        = b;
    req_alu_control[i*2 +: 2] = op;
    req_set_flags[i]          = sf;
    req_valid[i]              = 1'b1;
  endtask

  // Entered at a negedge with requests presented; leaves at a negedge after the handshake
  task automatic run_txn(input int stall, input logic [1:0] stall_rdy, output int gi);
    int n;
    logic [1:0] eg, oh;
    logic [W+3:0] e;
    n = 0;
    gi = -1;
    while (req_ready == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready == 2'b00) begin
      check("accept_timeout", 64'(req_ready), 64'(exp_grant(req_valid)));
      return;
    end
    eg = exp_grant(req_valid);
    check("req_ready_grant", 64'(req_ready), 64'(eg));
    gi = req_ready[1] ? 1 : 0;
    oh = (gi == 1) ? 2'b10 : 2'b01;
    e  = ref_alu(t_op[gi], t_a[gi], t_b[gi]);
    @(posedge clk);
    #1 req_valid[gi] = 1'b0;
    @(negedge clk);
    check("exec_rsp_valid", 64'(rsp_valid), 64'(2'b00));
    check("exec_req_ready", 64'(req_ready), 64'(2'b00));
    check("alu_srcA", 64'(alu_srcA), 64'(t_a[gi]));
    @(negedge clk);
    if (t_sf[gi]) exp_flags = e[3:0];
    check("rsp_valid", 64'(rsp_valid), 64'(oh));
    check("rsp_result", 64'(rsp_result), 64'(e[W+3:4]));
    check("rsp_flags", 64'(rsp_flags), 64'(e[3:0]));
    check("flags_nzcv", 64'(flags_nzcv), 64'(exp_flags));
    rsp_ready = stall_rdy & ~oh;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("hold_rsp_valid", 64'(rsp_valid), 64'(oh));
      check("hold_rsp_result", 64'(rsp_result), 64'(e[W+3:4]));
      check("hold_req_ready", 64'(req_ready), 64'(2'b00));
    end
    rsp_ready = oh;
    @(negedge clk);
    rr_next = (gi == 0);
    check("post_rsp_valid", 64'(rsp_valid), 64'(2'b00));
    check("post_flags", 64'(flags_nzcv), 64'(exp_flags));
    check("idle_req_ready", 64'(req_ready), 64'(exp_grant(req_valid)));
    rsp_ready = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rr_next = (PRIO != 0);
    exp_flags = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req_valid = 2'b00; req_set_flags = 2'b00; rsp_ready = 2'b00;
    req_srcA = '0; req_srcB = '0; req_alu_control = 4'b0000;
    rr_next = (PRIO != 0);
    exp_flags = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    req_valid = 2'b01;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'(2'b00));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(2'b00));
    check("rst_rsp_result", 64'(rsp_result), 64'(0));
    check("rst_flags", 64'(flags_nzcv), 64'(0));
    check("rst_alu", 64'({alu_srcA, alu_srcB[W-1:W-2], alu_control}), 64'(0));
    req_valid = 2'b00;
    reset = 1'b0;

    // Single requester ADD 5+7 with flag update
    set_req(0, ALU_ADD, 32'd5, 32'd7, 1'b1);
    run_txn(0, 2'b00, g);
    check("t1_grant", 64'(g), 64'(0));
    check("t1_result", 64'(rsp_result), 64'(12));
    check("t1_flags", 64'(flags_nzcv), 64'(4'b0000));

    // SUB 3-3 sets Z; AND with no flag update leaves NZCV alone
    set_req(1, ALU_SUB, 32'd3, 32'd3, 1'b1);
    run_txn(0, 2'b00, g);
    check("t3_sub_result", 64'(rsp_result), 64'(0));
    check("t3_sub_z", 64'(flags_nzcv[FLAG_Z]), 64'(1));
    set_req(0, ALU_AND, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_txn(0, 2'b00, g);
    check("t3_and_n", 64'(rsp_flags[FLAG_N]), 64'(1));
    check("t3_keep_z", 64'(flags_nzcv[FLAG_Z]), 64'(1));

    // Stalled response, then ready only on the non-tagged side
    set_req(0, ALU_OR, 32'h0F0F_0000, 32'h0000_F0F0, 1'b0);
    run_txn(5, 2'b00, g);
    set_req(1, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_txn(4, 2'b11, g);

    // Reset while the op is in EXEC drops it without touching flags
    set_req(1, ALU_SUB, 32'd1, 32'd2, 1'b1);
    @(posedge clk);
    #1 reset = 1'b1;
    req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    check("t5_rsp_valid", 64'(rsp_valid), 64'(2'b00));
    check("t5_flags", 64'(flags_nzcv), 64'(0));
    check("t5_rsp_result", 64'(rsp_result), 64'(0));
    check("t5_alu_srcA", 64'(alu_srcA), 64'(0));
    reset = 1'b0;
    rr_next = (PRIO != 0);
    exp_flags = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_no_rsp", 64'(rsp_valid), 64'(2'b00));
      check("t5_no_flags", 64'(flags_nzcv), 64'(0));
    end
    set_req(0, ALU_ADD, 32'd1, 32'd1, 1'b0);
    #1 check("t5_idle_ready", 64'(req_ready), 64'(2'b01));
    run_txn(0, 2'b00, g);

    // Contention: strict alternation starting with PRIO_INIT
    do_reset();
    set_req(0, ALU_ADD, 32'd10, 32'd20, 1'b0);
    set_req(1, ALU_SUB, 32'd20, 32'd10, 1'b0);
    for (int k = 0; k < 4; k++) begin
      run_txn(0, 2'b00, g);
      order[k] = g;
      if (g == 0) set_req(0, ALU_ADD, 32'(k), 32'd20, 1'b0);
      else if (g == 1) set_req(1, ALU_SUB, 32'd20, 32'(k), 1'b0);
    end
    check("t2_order0", 64'(order[0]), 64'(0));
    check("t2_order1", 64'(order[1]), 64'(1));
    check("t2_order2", 64'(order[2]), 64'(0));
    check("t2_order3", 64'(order[3]), 64'(1));

    // Random traffic: both requesters, random ops, stalls and stray rsp_ready
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, 2'($urandom_range(0, 3)), rnd_val(), rnd_val(), 1'($urandom_range(0, 1)));
      end
      if (req_valid == 2'b00)
        set_req(it % 2, 2'($urandom_range(0, 3)), rnd_val(), rnd_val(), 1'($urandom_range(0, 1)));
      run_txn(int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), g);
      if (g < 0) break;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
